wib_pll_lock_mgr: RTL and testbench
===================================

WIB_PLL_LOCK_MGR -- requirements
Module: wib_pll_lock_mgr

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3: number of downstream reset domains (1..16).
REQ-002 SHALL have parameter RST_PULSE_CYCLES, default 4: PLL reset pulse width in refclk cycles.
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 16: consecutive synced-lock cycles required before release.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 64: maximum wait for lock before retrying.
REQ-005 SHALL have parameter STAGGER_CYCLES, default 8: spacing between successive domain reset releases.
REQ-006 SHALL have parameter CNT_W, default 8: width of the statistics counters.
REQ-007 SHALL have port refclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port pll_locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-010 SHALL have port force_relock, input, 1 bit: one-cycle request to reset the PLL and all domains.
REQ-011 SHALL have port clr_cnt, input, 1 bit: clears both statistics counters.
REQ-012 SHALL have port pll_rst, output, 1 bit: reset to the PLL.
REQ-013 SHALL have port domain_rst, output, N_DOMAINS bits: per-domain active-high resets.
REQ-014 SHALL have port all_ready, output, 1 bit: high when all domains are released and the lock is stable.
REQ-015 SHALL have port lock_lost_cnt, output, CNT_W bits: count of lock losses seen in RUN.
REQ-016 SHALL have port retry_cnt, output, CNT_W bits: count of lock-wait timeouts.
REQ-017 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-018 SHALL pass pll_locked through a 2-flop synchronizer; all decisions use the synced value (lock_s).
REQ-019 SHALL implement the FSM states PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3 and RUN=4, with a single down-counting timer shared by all states.
REQ-020 SHALL behave as follows in PLL_RST: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
REQ-021 SHALL behave as follows in WAIT_LOCK: lock_s=1 goes to STABLE; after LOCK_TIMEOUT_CYCLES cycles without lock, retry_cnt increments and the FSM goes to PLL_RST.
REQ-022 SHALL behave as follows in STABLE: after LOCK_STABLE_CYCLES consecutive cycles with lock_s=1, go to RELEASE; any lock_s=0 returns to WAIT_LOCK with a fresh timeout.
REQ-023 SHALL behave as follows in RELEASE: domain_rst[0] clears on the first RELEASE cycle, domain_rst[i] clears STAGGER_CYCLES*i cycles later, and the FSM enters RUN STAGGER_CYCLES cycles after domain_rst[N_DOMAINS-1] clears.
REQ-024 SHALL hold all_ready=1 only in RUN.
REQ-025 SHALL treat lock_s=0 in RELEASE or RUN as a loss: in the next cycle domain_rst becomes all ones, all_ready=0, pll_rst=1 and the FSM is in PLL_RST.
REQ-026 SHALL increment lock_lost_cnt on a loss only when the loss occurs in RUN.
REQ-027 SHALL make force_relock=1 in any state other than PLL_RST take the same action as a loss, with no counter increment; in PLL_RST, force_relock SHALL be ignored.
REQ-028 SHALL make both counters saturate at 2^CNT_W-1.
REQ-029 SHALL let clr_cnt take priority over a same-cycle increment, leaving the counter at 0.
REQ-030 SHALL keep domain_rst bits monotonic within one RELEASE pass, so that no bit re-asserts except on a full reset of all domains.
REQ-031 SHALL generate domain_rst in the refclk domain; each consuming domain synchronizes it.

Reset
REQ-032 SHALL, while rst=1, force state=PLL_RST, pll_rst=1, domain_rst all ones, all_ready=0, both counters=0, timer loaded with RST_PULSE_CYCLES and synchronizer flops=0.
REQ-033 SHALL, when rst is asserted mid-operation (any state), apply the reset values on the next edge, and then restart the full sequence starting with a complete pll_rst pulse.

Structure
REQ-034 SHALL place the state encodings and the default parameter constants in a shared package/include, wib_pll_pkg.
REQ-035 SHALL implement the synchronizer as the sub-module wib_sync2, which SHALL be reused by other blocks.
REQ-036 SHALL size the timer as clog2 of the maximum of all cycle parameters and of STAGGER_CYCLES*N_DOMAINS.

Verification (N_DOMAINS=3, defaults otherwise)
REQ-037 SHALL cover nominal bring-up: release rst, pll_locked=1 from cycle 0 -> pll_rst high for 4 cycles; domain_rst bits clear in order 0, 1, 2, 8 cycles apart; all_ready rises 8 cycles after bit 2 clears.
REQ-038 SHALL cover timeout: pll_locked held 0 -> pll_rst pulses every 68 cycles, retry_cnt=3 after 3 timeouts, domain_rst stays 3'b111.
REQ-039 SHALL cover a STABLE glitch: pll_locked drops for 1 cycle 10 cycles into STABLE -> FSM back to WAIT_LOCK, no release, full 16-cycle qualification repeated.
REQ-040 SHALL cover loss in RUN: pll_locked low for 2 cycles -> within 3 cycles of the fall domain_rst=3'b111, all_ready=0, pll_rst=1, lock_lost_cnt=1; the design then recovers fully.
REQ-041 SHALL cover saturation and clear: CNT_W=2 with 5 losses -> lock_lost_cnt=3; clr_cnt on the same cycle as a 6th loss -> lock_lost_cnt=0.
REQ-042 SHALL cover force and reset mid-operation: force_relock during RELEASE after bit 0 clears -> all bits reassert with counters unchanged; rst during RUN -> reset values on the next cycle.

Source files
------------

// File: rtl/wib_pll_pkg.sv
// Shared definitions for the PLL lock manager and its helpers.
// Holds the FSM state encodings, the default cycle constants and a small
// constant-evaluable helper used for timer sizing.
package wib_pll_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_N_DOMAINS           = 3;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 4;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 64;
  localparam int unsigned DEF_STAGGER_CYCLES      = 8;
  localparam int unsigned DEF_CNT_W               = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wib_sync2.sv
// Two-flop synchronizer for a single-bit level signal.
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset, clears both flops to RST_VAL
//   d   - asynchronous input
//   q   - synchronized output (two clk cycles of latency)
module wib_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wib_pll_lock_mgr.sv
// PLL lock manager: pulses the PLL reset, waits for a qualified lock, then
// releases downstream reset domains one after another, and tears everything
// down again on lock loss or on request. Keeps saturating statistics of
// lock losses and lock-wait timeouts.
// Ports:
//   refclk        - the only clock, rising edge
//   rst           - synchronous active-high reset
//   pll_locked    - PLL lock flag, asynchronous to refclk
//   force_relock  - single-cycle request to restart the whole sequence
//   clr_cnt       - clears both statistics counters
//   pll_rst       - reset to the PLL
//   domain_rst    - per-domain active-high resets (refclk domain)
//   all_ready     - all domains released and lock stable
//   lock_lost_cnt - number of lock losses seen while running
//   retry_cnt     - number of lock-wait timeouts
//   state         - current FSM state encoding
module wib_pll_lock_mgr
  import wib_pll_pkg::*;
#(
  parameter int unsigned N_DOMAINS           = DEF_N_DOMAINS,
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
  parameter int unsigned CNT_W               = DEF_CNT_W
) (
  input  logic                 refclk,
  input  logic                 rst,
  input  logic                 pll_locked,
  input  logic                 force_relock,
  input  logic                 clr_cnt,
  output logic                 pll_rst,
  output logic [N_DOMAINS-1:0] domain_rst,
  output logic                 all_ready,
  output logic [CNT_W-1:0]     lock_lost_cnt,
  output logic [CNT_W-1:0]     retry_cnt,
  output logic [2:0]           state
);

  localparam int unsigned REL_CYCLES = STAGGER_CYCLES * N_DOMAINS;
  localparam int unsigned TMR_MAX    = max_u(max_u(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES),
                                             max_u(LOCK_TIMEOUT_CYCLES,
                                                   max_u(STAGGER_CYCLES, REL_CYCLES)));
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

  typedef logic [TMR_W-1:0] tmr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam tmr_t T_RST = tmr_t'(RST_PULSE_CYCLES);
  localparam tmr_t T_STB = tmr_t'(LOCK_STABLE_CYCLES);
  localparam tmr_t T_TO  = tmr_t'(LOCK_TIMEOUT_CYCLES);
  localparam tmr_t T_REL = tmr_t'(REL_CYCLES);
  localparam tmr_t T_ONE = tmr_t'(1);

  logic lock_s;

  wib_sync2 #(.RST_VAL(1'b0)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  pll_state_e           cur_st;
  pll_state_e           nxt_st;
  tmr_t                 tmr_q;
  tmr_t                 tmr_d;
  tmr_t                 rel_el;
  logic                 loss;
  logic                 relock;
  logic                 lost_inc;
  logic                 retry_inc;
  logic                 pll_rst_d;
  logic                 all_ready_d;
  logic [N_DOMAINS-1:0] dom_d;

  always_comb begin
    nxt_st    = cur_st;
    tmr_d     = tmr_q;
    retry_inc = 1'b0;
    loss      = ((cur_st == RELEASE) || (cur_st == RUN)) && !lock_s;
    lost_inc  = (cur_st == RUN) && !lock_s;
    relock    = loss || (force_relock && (cur_st != PLL_RST));

    if (relock) begin
      nxt_st = PLL_RST;
      tmr_d  = T_RST;
    end else begin
      case (cur_st)
        PLL_RST: begin
          if (tmr_q <= T_ONE) begin
            nxt_st = WAIT_LOCK;
            tmr_d  = T_TO;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt_st = STABLE;
            tmr_d  = T_STB;
          end else if (tmr_q <= T_ONE) begin
            nxt_st    = PLL_RST;
            tmr_d     = T_RST;
            retry_inc = 1'b1;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            nxt_st = WAIT_LOCK;
            tmr_d  = T_TO;
          end else if (tmr_q <= T_ONE) begin
            nxt_st = RELEASE;
            tmr_d  = T_REL;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        RELEASE: begin
          if (tmr_q <= T_ONE) begin
            nxt_st = RUN;
            tmr_d  = '0;
          end else begin
            tmr_d = tmr_q - T_ONE;
          end
        end
        RUN: begin
          tmr_d = '0;
        end
        default: begin
          nxt_st = PLL_RST;
          tmr_d  = T_RST;
        end
      endcase
    end

    // Outputs are registered, so they are decoded from the next state and
    // next timer value; the release schedule is elapsed = T_REL - timer.
    pll_rst_d   = (nxt_st == PLL_RST);
    all_ready_d = (nxt_st == RUN);
    rel_el      = T_REL - tmr_d;
    dom_d       = '1;
    for (int unsigned i = 0; i < N_DOMAINS; i++) begin
      if (nxt_st == RUN) begin
        dom_d[i] = 1'b0;
      end else if (nxt_st == RELEASE) begin
        dom_d[i] = (rel_el < tmr_t'(STAGGER_CYCLES * i));
      end
    end
    // A bit, once released in this pass, stays released.
    if ((cur_st == RELEASE) && (nxt_st == RELEASE)) begin
      dom_d = dom_d & domain_rst;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_st        <= PLL_RST;
      tmr_q         <= T_RST;
      pll_rst       <= 1'b1;
      domain_rst    <= '1;
      all_ready     <= 1'b0;
      lock_lost_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      cur_st     <= nxt_st;
      tmr_q      <= tmr_d;
      pll_rst    <= pll_rst_d;
      domain_rst <= dom_d;
      all_ready  <= all_ready_d;

      if (clr_cnt) begin
        lock_lost_cnt <= '0;
      end else if (lost_inc && (lock_lost_cnt != '1)) begin
        lock_lost_cnt <= lock_lost_cnt + cnt_t'(1);
      end

      if (clr_cnt) begin
        retry_cnt <= '0;
      end else if (retry_inc && (retry_cnt != '1)) begin
        retry_cnt <= retry_cnt + cnt_t'(1);
      end
    end
  end

  assign state = cur_st;

endmodule

// File: tb/tb_wib_pll_lock_mgr.sv
module tb_wib_pll_lock_mgr;

  localparam int ND   = 3;
  localparam int RSTP = 4;
  localparam int STB  = 16;
  localparam int TO   = 64;
  localparam int STAG = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          force_relock;
  logic          clr_cnt;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          all_ready;
  logic [CW-1:0] lock_lost_cnt;
  logic [CW-1:0] retry_cnt;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  // reference model: phase number, cycles spent in the phase, sync pipe, counters
  int   m_ph, m_el, m_lost, m_retry;
  logic m_ls1, m_ls2;

  int   t_pf, t_r, t_s2, t_s3, nr, hold;
  int   t_d[ND];
  int   rises[4];
  logic prev, dom_ok, saw_wait;

  always #5 refclk = ~refclk;

  wib_pll_lock_mgr #(
    .N_DOMAINS           (ND),
    .RST_PULSE_CYCLES    (RSTP),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STAGGER_CYCLES      (STAG),
    .CNT_W               (CW)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .force_relock  (force_relock),
    .clr_cnt       (clr_cnt),
    .pll_rst       (pll_rst),
    .domain_rst    (domain_rst),
    .all_ready     (all_ready),
    .lock_lost_cnt (lock_lost_cnt),
    .retry_cnt     (retry_cnt),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic lk;
    logic inc_l, inc_r;
    if (rst) begin
      m_ph = 0; m_el = 0; m_lost = 0; m_retry = 0; m_ls1 = 1'b0; m_ls2 = 1'b0;
    end else begin
      lk    = m_ls2;
      m_ls2 = m_ls1;
      m_ls1 = pll_locked;
      inc_l = (m_ph == 4) && !lk;
      inc_r = 1'b0;
      if ((m_ph >= 3 && !lk) || (force_relock && m_ph != 0)) begin
        m_ph = 0; m_el = 0;
      end else begin
        case (m_ph)
          0: if (m_el + 1 == RSTP) begin m_ph = 1; m_el = 0; end else m_el++;
          1: if (lk) begin m_ph = 2; m_el = 0; end
             else if (m_el + 1 == TO) begin m_ph = 0; m_el = 0; inc_r = 1'b1; end
             else m_el++;
          2: if (!lk) begin m_ph = 1; m_el = 0; end
             else if (m_el + 1 == STB) begin m_ph = 3; m_el = 0; end
             else m_el++;
          3: if (m_el + 1 == STAG * ND) begin m_ph = 4; m_el = 0; end else m_el++;
          default: m_el = 0;
        endcase
      end
      if (clr_cnt) m_lost = 0; else if (inc_l && m_lost < CMAX) m_lost++;
      if (clr_cnt) m_retry = 0; else if (inc_r && m_retry < CMAX) m_retry++;
    end
  endtask

  task automatic step();
    logic [ND-1:0] e_dom;
    @(posedge refclk);
    model_edge();
    #1;
    for (int i = 0; i < ND; i++)
      e_dom[i] = (m_ph == 4) ? 1'b0 : (m_ph == 3) ? (m_el < STAG * i) : 1'b1;
    chk("cyc_state", state, m_ph);
    chk("cyc_pll_rst", pll_rst, (m_ph == 0));
    chk("cyc_domain_rst", domain_rst, e_dom);
    chk("cyc_all_ready", all_ready, (m_ph == 4));
    chk("cyc_lock_lost_cnt", lock_lost_cnt, m_lost);
    chk("cyc_retry_cnt", retry_cnt, m_retry);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (all_ready !== 1'b1 && n < budget) begin step(); n++; end
    chk("wait_ready", all_ready, 1);
  endtask

  task automatic wait_state(input int s, input int budget);
    int n = 0;
    while (state !== 3'(s) && n < budget) begin step(); n++; end
    chk("wait_state", state, s);
  endtask

  initial begin
    rst = 1'b1; pll_locked = 1'b1; force_relock = 1'b0; clr_cnt = 1'b0;
    repeat (3) step();
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    chk("reset_domain_rst", domain_rst, 3'b111);
    chk("reset_all_ready", all_ready, 0);
    chk("reset_lost", lock_lost_cnt, 0);
    chk("reset_retry", retry_cnt, 0);

    // nominal bring-up
    rst = 1'b0;
    t_pf = -1; t_r = -1;
    for (int i = 0; i < ND; i++) t_d[i] = -1;
    for (int n = 1; n <= 120 && t_r < 0; n++) begin
      step();
      if (t_pf < 0 && pll_rst === 1'b0) t_pf = n;
      for (int i = 0; i < ND; i++) if (t_d[i] < 0 && domain_rst[i] === 1'b0) t_d[i] = n;
      if (t_r < 0 && all_ready === 1'b1) t_r = n;
    end
    chk("bringup_pll_rst_len", t_pf, RSTP);
    chk("bringup_d0_at", t_d[0], 21);
    chk("bringup_d1_gap", t_d[1] - t_d[0], STAG);
    chk("bringup_d2_gap", t_d[2] - t_d[1], STAG);
    chk("bringup_ready_gap", t_r - t_d[2], STAG);

    // lock never arrives: periodic retries
    rst = 1'b1; pll_locked = 1'b0;
    step(); step();
    rst = 1'b0;
    nr = 0; prev = 1'b1; dom_ok = 1'b1;
    for (int n = 1; n <= 210; n++) begin
      step();
      if (pll_rst === 1'b1 && prev === 1'b0 && nr < 4) begin rises[nr] = n; nr++; end
      prev = pll_rst;
      if (domain_rst !== 3'b111) dom_ok = 1'b0;
    end
    chk("timeout_rises", nr, 3);
    chk("timeout_first", rises[0], 68);
    chk("timeout_period1", rises[1] - rises[0], 68);
    chk("timeout_period2", rises[2] - rises[1], 68);
    chk("timeout_retry", retry_cnt, 3);
    chk("timeout_domains_held", dom_ok, 1);

    // one-cycle glitch during qualification
    pll_locked = 1'b1;
    wait_state(2, 120);
    repeat (10) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    saw_wait = 1'b0; t_s2 = -1; t_s3 = -1; dom_ok = 1'b1;
    for (int n = 1; n <= 60 && t_s3 < 0; n++) begin
      step();
      if (state === 3'd1) saw_wait = 1'b1;
      if (saw_wait && t_s2 < 0 && state === 3'd2) t_s2 = n;
      if (state === 3'd3) begin
        if (t_s2 >= 0) t_s3 = n; else dom_ok = 1'b0;
      end else if (domain_rst !== 3'b111) dom_ok = 1'b0;
    end
    chk("glitch_back_to_wait", saw_wait, 1);
    chk("glitch_requalify", t_s3 - t_s2, STB);
    chk("glitch_no_early_release", dom_ok, 1);

    // lock loss while running
    wait_ready(200);
    pll_locked = 1'b0;
    step(); step();
    pll_locked = 1'b1;
    step();
    chk("loss_domain_rst", domain_rst, 3'b111);
    chk("loss_all_ready", all_ready, 0);
    chk("loss_pll_rst", pll_rst, 1);
    chk("loss_lost_cnt", lock_lost_cnt, 1);
    wait_ready(200);

    // saturation and clear
    for (int k = 0; k < 4; k++) begin
      wait_ready(200);
      pll_locked = 1'b0;
      step(); step();
      pll_locked = 1'b1;
      step();
    end
    chk("sat_lost_cnt", lock_lost_cnt, 3);
    wait_ready(200);
    pll_locked = 1'b0;
    step(); step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    pll_locked = 1'b1;
    chk("clr_wins_lost_cnt", lock_lost_cnt, 0);
    chk("clr_loss_state", state, 0);

    // forced relock from RUN and from RELEASE
    wait_ready(200);
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force_run_pll_rst", pll_rst, 1);
    chk("force_run_lost", lock_lost_cnt, 0);
    wait_state(3, 120);
    step(); step();
    force_relock = 1'b1;
    step();
    force_relock = 1'b0;
    chk("force_rel_domain_rst", domain_rst, 3'b111);
    chk("force_rel_state", state, 0);
    chk("force_rel_lost", lock_lost_cnt, 0);
    chk("force_rel_retry", retry_cnt, 0);

    // reset while running, then a full pll_rst pulse
    wait_ready(200);
    rst = 1'b1;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_pll_rst", pll_rst, 1);
    chk("midrst_domain_rst", domain_rst, 3'b111);
    chk("midrst_all_ready", all_ready, 0);
    rst = 1'b0;
    t_pf = -1;
    for (int n = 1; n <= 20 && t_pf < 0; n++) begin
      step();
      if (pll_rst === 1'b0) t_pf = n;
    end
    chk("midrst_pulse_len", t_pf, RSTP);

    // randomized traffic against the model
    hold = 0;
    for (int k = 0; k < 2500; k++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = pll_locked ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 80));
      end
      hold--;
      force_relock = ($urandom_range(0, 199) == 0);
      clr_cnt      = ($urandom_range(0, 149) == 0);
      rst          = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
